// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu16 between two valid/ready requesters.
// One command in flight; result returned on a single tagged response channel.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic            grant_any;
    logic            grant_id;
    logic [3:0]      win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic            win_cin;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0101) ||
               (op == 4'b0110) || (op == 4'b0111);
    endfunction

    // Grant: lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = ~reset & (state == IDLE) & grant_any & ~grant_id;
        req1_ready = ~reset & (state == IDLE) & grant_any & grant_id;
        win_op     = grant_id ? req1_opcode : req0_opcode;
        win_a      = grant_id ? req1_a      : req0_a;
        win_b      = grant_id ? req1_b      : req0_b;
        win_cin    = grant_id ? req1_cin    : req0_cin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            alu_cin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_sel    <= win_op;
                        alu_a      <= win_a;
                        alu_b      <= win_b;
                        alu_cin    <= win_cin;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        if (op_legal(win_op)) begin
                            cnt   <= CW'(ALU_LAT - 1);
                            state <= ISSUE;
                        end else begin
                            // Illegal opcode skips the ALU entirely.
                            rsp_result <= '0;
                            rsp_cout   <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_cout   <= alu_cout;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model on an ALU_LAT=1 instance,
// directed latency/reset steps on an ALU_LAT=3 instance.
module tb_alu_arbiter;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- instance 1: ALU_LAT = 1 ----------------
    logic        rst, rsp_rdy;
    logic        vld [2];
    cmd_t        cmd [2];
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_err, alu_cin, alu_cout;
    logic [15:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;

    // ---------------- instance 3: ALU_LAT = 3 ----------------
    logic        rst3, v3_0, v3_1, rsp3_rdy;
    logic [3:0]  op3_0, op3_1;
    logic [15:0] a3_0, b3_0, a3_1, b3_1;
    logic        rdy3_0, rdy3_1, rsp3_valid, rsp3_id, rsp3_cout, rsp3_err, alu3_cin, alu3_cout;
    logic [15:0] rsp3_result, alu3_a, alu3_b, alu3_result;
    logic [3:0]  alu3_sel;

    // Stand-in for alu16 (mode 0); illegal selects produce junk that must never be sampled.
    function automatic logic [16:0] alu_f(input logic [3:0] sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        case (sel)
            4'h0:    return 17'(a) + 17'(b) + 17'(cin);
            4'h1:    return 17'(a) + 17'(~b) + 17'(cin);
            4'h5:    return {1'b0, a & b};
            4'h6:    return {1'b0, a | b};
            4'h7:    return {1'b0, a ^ b};
            default: return {1'b1, ~(a ^ b)};
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h5, 4'h6, 4'h7};
    endfunction

    assign {alu_cout, alu_result}   = alu_f(alu_sel, alu_a, alu_b, alu_cin);
    assign {alu3_cout, alu3_result} = alu_f(alu3_sel, alu3_a, alu3_b, alu3_cin);

    alu_arbiter #(.ALU_LAT(1), .WIDTH(16)) dut (
        .clk(clk), .reset(rst),
        .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_opcode(cmd[0].op),
        .req0_a(cmd[0].a), .req0_b(cmd[0].b), .req0_cin(cmd[0].cin),
        .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_opcode(cmd[1].op),
        .req1_a(cmd[1].a), .req1_b(cmd[1].b), .req1_cin(cmd[1].cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    alu_arbiter #(.ALU_LAT(3), .WIDTH(16)) dut3 (
        .clk(clk), .reset(rst3),
        .req0_valid(v3_0), .req0_ready(rdy3_0), .req0_opcode(op3_0),
        .req0_a(a3_0), .req0_b(b3_0), .req0_cin(1'b0),
        .req1_valid(v3_1), .req1_ready(rdy3_1), .req1_opcode(op3_1),
        .req1_a(a3_1), .req1_b(b3_1), .req1_cin(1'b0),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_rdy), .rsp_id(rsp3_id),
        .rsp_result(rsp3_result), .rsp_cout(rsp3_cout), .rsp_err(rsp3_err),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_sel(alu3_sel), .alu_cin(alu3_cin),
        .alu_result(alu3_result), .alu_cout(alu3_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction model: busy flag, edges remaining until the response shows, last winner.
    bit   m_busy = 0;
    int   m_cnt  = 0;
    bit   m_last = 1;
    bit   m_id   = 0;
    cmd_t m_cmd  = '0;
    cmd_t m_alu  = '0;
    bit   acc [2];
    bit   collect = 0;
    bit   ids [$];

    task automatic step();
        bit   e_rdy [2];
        bit   any;
        bit   w;
        logic [16:0] e_res;
        @(negedge clk);
        any = vld[0] || vld[1];
        w   = (vld[0] && vld[1]) ? !m_last : vld[1];
        e_rdy[0] = !rst && !m_busy && any && !w;
        e_rdy[1] = !rst && !m_busy && any && w;
        chk("req0_ready", 64'(req0_ready), 64'(e_rdy[0]));
        chk("req1_ready", 64'(req1_ready), 64'(e_rdy[1]));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_cnt == 0));
        if (m_busy && m_cnt == 0) begin
            e_res = is_legal(m_cmd.op) ? alu_f(m_cmd.op, m_cmd.a, m_cmd.b, m_cmd.cin) : 17'h0;
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_result", 64'(rsp_result), 64'(e_res[15:0]));
            chk("rsp_cout", 64'(rsp_cout), 64'(e_res[16]));
            chk("rsp_err", 64'(rsp_err), 64'(!is_legal(m_cmd.op)));
        end
        chk("alu_bus", 64'({alu_sel, alu_a, alu_b, alu_cin}), 64'(m_alu));
        if (collect && rsp_valid && rsp_rdy) ids.push_back(rsp_id);
        @(posedge clk);
        acc[0] = 0;
        acc[1] = 0;
        if (rst) begin
            m_busy = 0; m_last = 1; m_alu = '0;
        end else if (m_busy) begin
            if (m_cnt > 0) m_cnt--;
            else if (rsp_rdy) m_busy = 0;
        end else if (any) begin
            acc[w] = 1; m_cmd = cmd[w]; m_alu = cmd[w]; m_id = w; m_last = w; m_busy = 1;
            m_cnt = is_legal(cmd[w].op) ? 1 : 0;
        end
        #1;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        logic [3:0] ops [5] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7};
        c.op  = ($urandom_range(0, 99) < 15) ? 4'($urandom) : ops[$urandom_range(0, 4)];
        c.a   = 16'($urandom);
        c.b   = 16'($urandom);
        c.cin = 1'($urandom);
        return c;
    endfunction

    initial begin
        rst = 1; rsp_rdy = 1; vld[0] = 0; vld[1] = 0; cmd[0] = '0; cmd[1] = '0;
        rst3 = 1; v3_0 = 0; v3_1 = 0; rsp3_rdy = 1;
        op3_0 = '0; op3_1 = '0; a3_0 = '0; b3_0 = '0; a3_1 = '0; b3_1 = '0;
        acc[0] = 0; acc[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        vld[0] = 1; vld[1] = 1;
        @(negedge clk);
        chk("reset_ready0", 64'(req0_ready), 64'(0));
        chk("reset_ready1", 64'(req1_ready), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err}), 64'(0));
        chk("reset_alu", 64'({alu_sel, alu_a, alu_b, alu_cin}), 64'(0));
        @(posedge clk);
        #1;
        rst = 0; vld[0] = 0; vld[1] = 0;

        // Single ADD on req0
        vld[0] = 1; cmd[0] = '{op: 4'h0, a: 16'hFFFF, b: 16'h0001, cin: 1'b0};
        step();
        vld[0] = 0;
        chk("add_not_yet", 64'(rsp_valid), 64'(0));
        step();
        chk("add_valid", 64'(rsp_valid), 64'(1));
        chk("add_result", 64'(rsp_result), 64'(16'h0000));
        chk("add_cout", 64'(rsp_cout), 64'(1));
        chk("add_id", 64'(rsp_id), 64'(0));
        step();

        // Both valid continuously: grants must alternate
        vld[0] = 1; cmd[0] = '{op: 4'h5, a: 16'h00FF, b: 16'h0F0F, cin: 1'b0};
        vld[1] = 1; cmd[1] = '{op: 4'h7, a: 16'h00FF, b: 16'h0F0F, cin: 1'b0};
        collect = 1;
        repeat (20) step();
        collect = 0;
        vld[0] = 0; vld[1] = 0;
        repeat (4) step();
        chk("alt_count", 64'(ids.size() >= 4), 64'(1));
        if (ids.size() > 0) chk("alt_first", 64'(ids[0]), 64'(1));
        for (int i = 1; i < ids.size(); i++) chk("alt_toggle", 64'(ids[i] ^ ids[i-1]), 64'(1));

        // Response backpressure with req1 waiting
        vld[0] = 1; cmd[0] = '{op: 4'h1, a: 16'h1000, b: 16'h0001, cin: 1'b1};
        step();
        vld[0] = 0;
        vld[1] = 1; cmd[1] = '{op: 4'h6, a: 16'hA000, b: 16'h000A, cin: 1'b0};
        rsp_rdy = 0;
        repeat (6) step();
        rsp_rdy = 1;
        step();
        step();
        chk("bp_req1_taken", 64'(acc[1]), 64'(1));
        vld[1] = 0;
        repeat (3) step();

        // Illegal opcode on req1
        vld[1] = 1; cmd[1] = '{op: 4'hF, a: 16'h1234, b: 16'h5678, cin: 1'b1};
        step();
        vld[1] = 0;
        chk("ill_valid", 64'(rsp_valid), 64'(1));
        chk("ill_err", 64'(rsp_err), 64'(1));
        chk("ill_result", 64'({rsp_result, rsp_cout}), 64'(0));
        chk("ill_id", 64'(rsp_id), 64'(1));
        chk("ill_alu_sel", 64'(alu_sel), 64'(4'hF));
        step();
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!vld[i] || acc[i]) begin
                    vld[i] = ($urandom_range(0, 99) < 60);
                    cmd[i] = rand_cmd();
                end
            end
            rsp_rdy = ($urandom_range(0, 99) < 70);
            rst     = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 0; vld[0] = 0; vld[1] = 0; rsp_rdy = 1;

        // ALU_LAT=3: OR with operands held three cycles
        @(posedge clk);
        #1;
        rst3 = 0;
        v3_0 = 1; op3_0 = 4'h6; a3_0 = 16'h1234; b3_0 = 16'h4321;
        @(negedge clk);
        chk("l3_ready0", 64'(rdy3_0), 64'(1));
        @(posedge clk);
        #1;
        v3_0 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("l3_alu_hold", 64'({alu3_sel, alu3_a, alu3_b}), 64'({4'h6, 16'h1234, 16'h4321}));
            chk("l3_not_yet", 64'(rsp3_valid), 64'(0));
            @(posedge clk);
        end
        @(negedge clk);
        chk("l3_valid", 64'(rsp3_valid), 64'(1));
        chk("l3_result", 64'(rsp3_result), 64'(16'h5335));
        chk("l3_err", 64'(rsp3_err), 64'(0));
        @(posedge clk);
        #1;

        // Reset during ISSUE drops the command
        v3_1 = 1; op3_1 = 4'h7; a3_1 = 16'hF0F0; b3_1 = 16'h0FF0;
        @(posedge clk);
        #1;
        v3_1 = 0;
        rst3 = 1;
        @(negedge clk);
        chk("l3_rst_ready", 64'(rdy3_0), 64'(0));
        @(posedge clk);
        #1;
        rst3 = 0;
        @(negedge clk);
        chk("l3_rst_rsp", 64'(rsp3_valid), 64'(0));
        chk("l3_rst_alu", 64'({alu3_sel, alu3_a, alu3_b, alu3_cin}), 64'(0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("l3_no_ghost", 64'(rsp3_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        v3_0 = 1; v3_1 = 1;
        @(negedge clk);
        chk("l3_prio0", 64'({rdy3_0, rdy3_1}), 64'(2'b10));
        @(posedge clk);
        #1;
        v3_0 = 0; v3_1 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares a single combinational alu16 instance between two requesters. Each requester uses a valid/ready request channel. The block performs round-robin arbitration, registers the winning operands and drives them onto the ALU for a fixed settle time. It captures result and carry-out, and returns them on a single valid/ready response channel tagged with the requester ID. It sits between the command sources and alu16, with alu16 mode tied to 0 (arithmetic/logic set used by the team).

Parameters:
ALU_LAT, 1, cycles operands are held on the ALU before result capture (legal 1..15)
WIDTH, 16, operand/result width (matches alu16)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_opcode  in  4  requester 0 ALU select
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_cin  in  1  requester 0 carry-in
req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_cin  as requester 0, for requester 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that issued the command
rsp_result  out  WIDTH  captured ALU result
rsp_cout  out  1  captured ALU carry-out
rsp_err  out  1  illegal opcode flag
alu_a  out  WIDTH  to alu16 a
alu_b  out  WIDTH  to alu16 b
alu_sel  out  4  to alu16 sel
alu_cin  out  1  to alu16 Cin
alu_result  in  WIDTH  from alu16 result
alu_cout  in  1  from alu16 Cout

Behaviour:
- Reset (sync, high): state=IDLE; req*_ready=0 during reset; rsp_valid=0; rsp_id/rsp_result/rsp_cout/rsp_err=0; alu_a/alu_b/alu_sel/alu_cin=0; wait counter=0; last_grant=1, so req0 has priority first.
- Reset asserted in any state drops the in-flight command. No response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: grant is combinational. If exactly one valid, that requester wins. If both are valid, the requester != last_grant wins. Only the winner's ready=1 and only in IDLE. The loser's ready=0. A valid with no grant is held by the requester and must not be dropped.
- Accept = reqN_valid & reqN_ready at a rising edge. On accept: register opcode/a/b/cin onto alu_*, store id, set last_grant=id.
  - Legal opcode (0000 ADD, 0001 SUB, 0101 AND, 0110 OR, 0111 XOR): go to ISSUE with counter=ALU_LAT-1.
  - Illegal opcode: go directly to RESP with rsp_err=1, rsp_result=0, rsp_cout=0. No ALU cycles are used.
- ISSUE: alu_* held stable. Decrement counter each cycle. In the cycle counter==0, capture alu_result→rsp_result and alu_cout→rsp_cout, set rsp_err=0, and go to RESP.
- RESP: rsp_valid=1. rsp_id/rsp_result/rsp_cout/rsp_err held stable until rsp_ready=1 at a rising edge, then go to IDLE with rsp_valid=0. No new command is accepted in RESP; no pipelining, one command in flight.
- Latency: for a legal command accepted at edge T, rsp_valid rises after edge T+ALU_LAT. An illegal command gives rsp_valid after edge T. Minimum issue interval is ALU_LAT+2 cycles with rsp_ready tied high.
- alu_* keep their last value outside ISSUE and are not cleared on return to IDLE.
- rsp_result/rsp_cout are passed through from alu16 unmodified. The block performs no arithmetic.
- Starvation-free: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- All outputs are registered except req*_ready, which is combinational from state, valids and last_grant.

Test Plan:
- Reset then single ADD on req0: a=FFFF, b=0001, cin=0, ALU_LAT=1 → req0_ready pulses one cycle; rsp_valid two edges after accept; rsp_id=0, rsp_result=0000, rsp_cout=1, rsp_err=0.
- Both valid continuously: req0 AND a=00FF b=0F0F, req1 XOR a=00FF b=0F0F → responses alternate id 0 (result 000F), id 1 (0FF0), id 0, id 1; no two consecutive grants to the same ID.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with req1_valid=1 → rsp_* stable all 5 cycles, req1_ready=0 throughout; req1 accepted the cycle after the rsp handshake.
- Illegal opcode 4'b1111 on req1 → rsp_valid the cycle after accept; rsp_err=1, rsp_result=0000, rsp_cout=0, rsp_id=1; alu_sel shows 1111 but the result is not sampled.
- ALU_LAT=3, OR a=1234 b=4321 → alu_* stable for 3 cycles; rsp_result=5335 valid after edge T+3.
- Reset asserted in ISSUE → next cycle: state IDLE, rsp_valid=0, alu_*=0; no response ever appears for the dropped command; next request has req0 priority.
